serial_rx16: RTL and testbench

Serial-to-parallel frame receiver: the receive end of the bit-serial link whose transmitter walks a 16:1 mux select counter over a parallel word. It detects a start bit, distributes each incoming bit into its indexed position of a word (LSB first), checks an even-parity bit, and presents the word on a valid/ready output port. It sits between the serial pin logic and the datapath register file/bus.

---
 rtl/serial_rx16.sv | 93 +++++++++
 tb/tb_serial_rx16.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx16.sv
// serial_rx16 -- bit-serial frame receiver.
//
// Frame (one bit per en strobe): start(1), d[0]..d[WIDTH-1] LSB first,
// even parity bit. The assembled word is presented on a valid/ready port.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        bit strobe; sin is sampled only when en=1
//   sin       serial line (idles at 0)
//   data_out  received word, stable while valid=1
//   valid     data_out/par_err hold an unconsumed frame
//   ready     consumer accepts on valid&&ready
//   par_err   parity mismatch for the frame in data_out
//   overrun   sticky: a complete frame was dropped (output full)
//   busy      receiver is inside a frame (state != IDLE)
module serial_rx16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             par_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] shift;

  // Output register accepts a new frame when empty or being drained now.
  logic can_load;
  assign can_load = !valid || ready;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shift    <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      par_err  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      // Handshake drain; overridden below if a frame loads this cycle.
      if (valid && ready) valid <= 1'b0;

      if (en) begin
        case (state)
          IDLE: begin
            if (sin) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            shift[cnt] <= sin;
            // cnt saturates at the last index; PARITY ignores it.
            if (cnt == CW'(WIDTH - 1)) state <= PARITY;
            else                       cnt   <= cnt + CW'(1);
          end
          PARITY: begin
            if (can_load) begin
              data_out <= shift;
              par_err  <= (^shift) ^ sin;
              valid    <= 1'b1;
            end else begin
              overrun  <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_rx16.sv
module tb_serial_rx16;

  logic        clk = 1'b0;
  logic        rst, en, sin, ready;
  logic [15:0] data_out;
  logic        valid, par_err, overrun, busy;

  serial_rx16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .sin(sin),
    .data_out(data_out), .valid(valid), .ready(ready),
    .par_err(par_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model of the output port, driven by frame-level events the
  // bench itself knows about (start strobe, parity strobe).
  logic [15:0] m_data;
  logic        m_valid, m_perr, m_ovr, m_busy;
  logic [15:0] cur_word;
  logic        cur_err;
  bit          rand_rdy = 0;
  bit          chk_each = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_model();
    chk("rnd data_out", 32'(data_out), 32'(m_data));
    chk("rnd valid",    32'(valid),    32'(m_valid));
    chk("rnd par_err",  32'(par_err),  32'(m_perr));
    chk("rnd overrun",  32'(overrun),  32'(m_ovr));
    chk("rnd busy",     32'(busy),     32'(m_busy));
  endtask

  // kind: 0 ordinary cycle, 1 start strobe, 2 parity strobe
  task automatic cyc(input logic e, input logic s, input int kind);
    logic ld;
    if (rand_rdy) ready = 1'($urandom_range(0, 1));
    en  = e;
    sin = s;
    ld = (kind == 2) && e && (!m_valid || ready);
    if (kind == 2 && e && !ld) m_ovr = 1'b1;
    if (ld) begin
      m_valid = 1'b1; m_data = cur_word; m_perr = cur_err;
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
    if (e && kind == 1) m_busy = 1'b1;
    if (e && kind == 2) m_busy = 1'b0;
    @(posedge clk); #1;
    if (chk_each) chk_model();
  endtask

  task automatic gaps(input int gmin, input int gmax);
    int g;
    g = (gmin == gmax) ? gmin : int'($urandom_range(gmax, gmin));
    for (int i = 0; i < g; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 0);
  endtask

  // Start strobe plus data bits, with en=0 gaps before each data strobe.
  task automatic send_body(input logic [15:0] w, input logic p, input int gmin, input int gmax);
    cur_word = w;
    cur_err  = (^w) ^ p;
    cyc(1'b1, 1'b1, 1);
    for (int k = 0; k < 16; k++) begin
      gaps(gmin, gmax);
      cyc(1'b1, w[k], 0);
    end
  endtask

  task automatic send_par(input logic p);
    cyc(1'b1, p, 2);
  endtask

  task automatic send_frame(input logic [15:0] w, input logic p, input int gmin, input int gmax);
    send_body(w, p, gmin, gmax);
    gaps(gmin, gmax);
    send_par(p);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sin = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_data = '0; m_valid = 0; m_perr = 0; m_ovr = 0; m_busy = 0;
  endtask

  typedef struct {
    logic [15:0] word;
    logic        pbit;
    logic [15:0] exp_data;
    logic        exp_valid;
    logic        exp_perr;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    ready = 1'b0;
    vecs[0] = '{16'hA5C3, 1'b0, 16'hA5C3, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'hA5C3, 1'b1, 16'hA5C3, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};

    do_reset();
    chk("reset data_out", 32'(data_out), 32'h0);
    chk("reset valid",    32'(valid),    32'h0);
    chk("reset par_err",  32'(par_err),  32'h0);
    chk("reset overrun",  32'(overrun),  32'h0);
    chk("reset busy",     32'(busy),     32'h0);

    // Table: continuous en, ready held high.
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].word, vecs[i].pbit, 0, 0);
      chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d valid", i),    32'(valid),    32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d par_err", i),  32'(par_err),  32'(vecs[i].exp_perr));
      chk($sformatf("vec%0d overrun", i),  32'(overrun),  32'(vecs[i].exp_ovr));
      chk($sformatf("vec%0d busy", i),     32'(busy),     32'h0);
    end

    // Start bit sets busy after its edge.
    do_reset();
    cyc(1'b1, 1'b1, 1);
    chk("busy after start", 32'(busy), 32'h1);
    do_reset();

    // Output full: second frame dropped, overrun sticks through the drain.
    ready = 1'b0;
    send_frame(16'h1234, 1'b1, 0, 0);
    chk("ovr first data", 32'(data_out), 32'h1234);
    chk("ovr first valid", 32'(valid), 32'h1);
    chk("ovr first flag", 32'(overrun), 32'h0);
    send_frame(16'hFFFF, 1'b0, 0, 0);
    chk("ovr second data", 32'(data_out), 32'h1234);
    chk("ovr second valid", 32'(valid), 32'h1);
    chk("ovr second flag", 32'(overrun), 32'h1);
    ready = 1'b1;
    cyc(1'b0, 1'b0, 0);
    chk("ovr drain valid", 32'(valid), 32'h0);
    chk("ovr drain flag", 32'(overrun), 32'h1);
    chk("ovr drain data", 32'(data_out), 32'h1234);

    // Back-to-back, with the handshake landing on the second parity strobe.
    do_reset();
    ready = 1'b1;
    send_frame(16'h0001, 1'b1, 0, 0);
    chk("b2b first data", 32'(data_out), 32'h0001);
    chk("b2b first valid", 32'(valid), 32'h1);
    ready = 1'b0;
    send_body(16'h8000, 1'b1, 0, 0);
    chk("b2b hold valid", 32'(valid), 32'h1);
    ready = 1'b1;
    send_par(1'b1);
    chk("b2b second data", 32'(data_out), 32'h8000);
    chk("b2b second valid", 32'(valid), 32'h1);
    chk("b2b second perr", 32'(par_err), 32'h0);
    chk("b2b overrun", 32'(overrun), 32'h0);

    // en toggling every cycle: parity strobe lands 34 edges after start.
    do_reset();
    ready = 1'b0;
    send_body(16'h00FF, 1'b0, 1, 1);
    cyc(1'b0, 1'b1, 0);
    chk("toggle valid pre", 32'(valid), 32'h0);
    chk("toggle busy pre", 32'(busy), 32'h1);
    send_par(1'b0);
    chk("toggle valid", 32'(valid), 32'h1);
    chk("toggle data", 32'(data_out), 32'h00FF);
    chk("toggle perr", 32'(par_err), 32'h0);

    // Reset mid-frame, then a clean frame.
    send_body(16'hBEEF, 1'b0, 0, 0);
    do_reset();
    chk("midrst data", 32'(data_out), 32'h0);
    chk("midrst valid", 32'(valid), 32'h0);
    chk("midrst perr", 32'(par_err), 32'h0);
    chk("midrst busy", 32'(busy), 32'h0);
    send_frame(16'h0F0F, 1'b0, 0, 0);
    chk("postrst data", 32'(data_out), 32'h0F0F);
    chk("postrst valid", 32'(valid), 32'h1);
    chk("postrst perr", 32'(par_err), 32'h0);

    // Randomized: random words/parity, gaps, ready, checked each cycle.
    do_reset();
    rand_rdy = 1;
    chk_each = 1;
    for (int f = 0; f < 40; f++) begin
      int idle;
      idle = int'($urandom_range(2, 0));
      for (int i = 0; i < idle; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 0);
      send_frame(16'($urandom), 1'($urandom_range(0, 1)), 0, 2);
    end
    chk_each = 0;
    rand_rdy = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
